// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- single-outstanding load/store unit between execute and a simple
// valid/ready memory port.
//
// Accepts one load or store from execute while idle. A misaligned access is
// reported straight away as a fault and never reaches memory. An aligned
// access is sent to memory as a word-aligned request with byte strobes and
// lane-replicated store data. A load's extracted, extended result is returned
// through the writeback port. A store finishes when memory acknowledges it.
//
// States:
//   state | meaning
//   IDLE  | ready for a new request (req_ready_o = 1)
//   REQ   | memory request presented, waiting for mem_req_ready_i
//   WAIT  | request accepted, waiting for mem_rsp_valid_i
//   DONE  | load result or misalign fault held on wb_* until wb_ready_i
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_*                 request from execute (valid/ready handshake)
//   mem_req_*, mem_we_o,
//   mem_addr_o,
//   mem_wstrb_o,
//   mem_wdata_o           memory request channel
//   mem_rsp_valid_i,
//   mem_rdata_i           memory response (read data or write ack)
//   wb_*                  load result / fault report to writeback
// ---------------------------------------------------------------------------
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [4:0]      req_rd_i,

  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_wstrb_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rdata_i,

  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            wb_misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  state_t r_state;

  // Captured request
  logic            r_we;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [4:0]      r_rd;

  // Registered handshake / writeback outputs
  logic            r_req_ready;
  logic            r_mem_req_valid;
  logic            r_wb_valid;
  logic            r_wb_misalign;
  logic [XLEN-1:0] r_wb_data;

  logic            w_accept;
  logic            w_misalign;
  logic [3:0]      w_store_strb;
  logic [XLEN-1:0] w_store_data;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_load_data;

  assign w_accept = req_valid_i & r_req_ready;

  // Alignment is judged on the live request so a fault can skip memory.
  always_comb begin
    w_misalign = 1'b0;
    case (req_size_i)
      SZ_HALF: w_misalign = req_addr_i[0];
      SZ_WORD: w_misalign = (req_addr_i[1:0] != 2'b00);
      SZ_ILL:  w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
  end

  // Store lane steering, derived from the captured fields so it stays
  // stable for the whole time the request is presented.
  always_comb begin
    w_store_strb = 4'b1111;
    w_store_data = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_store_strb = 4'b0001 << r_addr[1:0];
        w_store_data = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_store_strb = 4'b0011 << r_addr[1:0];
        w_store_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_store_strb = 4'b1111;
        w_store_data = r_wdata;
      end
    endcase
  end

  // Load extraction: bring the addressed byte/half down to bit 0, then extend.
  assign w_lane = mem_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_data = mem_rdata_i;
    case (r_size)
      SZ_BYTE: w_load_data = r_unsigned ? {{(XLEN-8){1'b0}}, w_lane[7:0]}
                                        : {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      SZ_HALF: w_load_data = r_unsigned ? {{(XLEN-16){1'b0}}, w_lane[15:0]}
                                        : {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      default: w_load_data = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= S_IDLE;
      r_we            <= 1'b0;
      r_size          <= 2'd0;
      r_unsigned      <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_rd            <= 5'd0;
      r_req_ready     <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_wb_valid      <= 1'b0;
      r_wb_misalign   <= 1'b0;
      r_wb_data       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we_i;
            r_size      <= req_size_i;
            r_unsigned  <= req_unsigned_i;
            r_addr      <= req_addr_i;
            r_wdata     <= req_wdata_i;
            r_rd        <= req_rd_i;
            r_req_ready <= 1'b0;
            if (w_misalign) begin
              r_state       <= S_DONE;
              r_wb_valid    <= 1'b1;
              r_wb_misalign <= 1'b1;
              r_wb_data     <= '0;
            end else begin
              r_state         <= S_REQ;
              r_mem_req_valid <= 1'b1;
            end
          end
        end

        // A response in the handshake cycle belongs to nothing we issued.
        S_REQ: begin
          if (mem_req_ready_i) begin
            r_state         <= S_WAIT;
            r_mem_req_valid <= 1'b0;
          end
        end

        S_WAIT: begin
          if (mem_rsp_valid_i) begin
            if (r_we) begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
            end else begin
              r_state       <= S_DONE;
              r_wb_valid    <= 1'b1;
              r_wb_misalign <= 1'b0;
              r_wb_data     <= w_load_data;
            end
          end
        end

        // Ready only rises on the following cycle, so no re-accept here.
        S_DONE: begin
          if (wb_ready_i) begin
            r_state       <= S_IDLE;
            r_wb_valid    <= 1'b0;
            r_wb_misalign <= 1'b0;
            r_req_ready   <= 1'b1;
          end
        end

        default: begin
          r_state         <= S_IDLE;
          r_req_ready     <= 1'b1;
          r_mem_req_valid <= 1'b0;
          r_wb_valid      <= 1'b0;
          r_wb_misalign   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o     = r_req_ready;
  assign mem_req_valid_o = r_mem_req_valid;
  assign mem_we_o        = r_we;
  assign mem_addr_o      = {r_addr[XLEN-1:2], 2'b00};
  assign mem_wstrb_o     = r_we ? w_store_strb : 4'b0000;
  assign mem_wdata_o     = w_store_data;
  assign wb_valid_o      = r_wb_valid;
  assign wb_rd_o         = r_rd;
  assign wb_data_o       = r_wb_data;
  assign wb_misalign_o   = r_wb_misalign;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- directed and randomized checks of lsu against an arithmetic
// model of the load/store rules (alignment, strobes, replication, extension)
// and of the cycle-level handshake timing.
// ---------------------------------------------------------------------------
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_misalign_o;

  int total = 0;
  int bad   = 0;

  lsu #(.XLEN(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_we_i        (req_we_i),
    .req_size_i      (req_size_i),
    .req_unsigned_i  (req_unsigned_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .req_rd_i        (req_rd_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wstrb_o     (mem_wstrb_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rdata_i     (mem_rdata_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_rd_o         (wb_rd_o),
    .wb_data_o       (wb_data_o),
    .wb_misalign_o   (wb_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit m_misalign(input int size, input logic [31:0] addr);
    if (size == 3) return 1'b1;
    if (size == 1 && (addr % 2) != 0) return 1'b1;
    if (size == 2 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_strb(input bit we, input int size, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (!we) return 32'd0;
    if (size == 0) return 32'd1 << off;
    if (size == 1) return 32'd3 << off;
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input int size, input logic [31:0] wd);
    if (size == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input int size, input bit uns,
                                         input logic [31:0] addr, input logic [31:0] rd);
    int off = int'(addr % 4);
    logic [31:0] v = rd >> (8 * off);
    if (size == 0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One complete transaction, checked cycle by cycle.
  // mw: cycles mem_req_ready_i is held low; rw: extra cycles before the
  // response; ww: cycles wb_ready_i is held low; same_rsp: pulse a bogus
  // response in the request-handshake cycle.
  task automatic txn(input bit we, input int size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [4:0] rd, input logic [31:0] rdata,
                     input int mw, input int rw, input int ww, input bit same_rsp);
    bit          mis  = m_misalign(size, addr);
    logic [31:0] eadr = addr & 32'hFFFF_FFFC;
    logic [31:0] estb = m_strb(we, size, addr);
    logic [31:0] ewd  = m_wdata(size, wd);
    logic [31:0] eld  = m_load(size, uns, addr, rdata);

    chk("ready_before_accept", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = 2'(size);
    req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wd; req_rd_i = rd;
    tick();
    // Scramble the request bus: the DUT must work from its captured copy.
    req_valid_i = 1'b0; req_we_i = ~we; req_addr_i = $urandom;
    req_wdata_i = $urandom; req_rd_i = 5'($urandom); req_size_i = 2'($urandom);
    req_unsigned_i = ~uns;

    if (mis) begin
      for (int i = 0; i <= ww; i++) begin
        chk("mis_no_memreq", 32'(mem_req_valid_o), 32'd0);
        chk("mis_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("mis_flag", 32'(wb_misalign_o), 32'd1);
        chk("mis_wb_data", wb_data_o, 32'd0);
        chk("mis_wb_rd", 32'(wb_rd_o), 32'(rd));
        chk("mis_ready_low", 32'(req_ready_o), 32'd0);
        wb_ready_i = (i == ww);
        tick();
      end
      wb_ready_i = 1'b0;
    end else begin
      for (int i = 0; i <= mw; i++) begin
        chk("memreq_valid", 32'(mem_req_valid_o), 32'd1);
        chk("mem_we", 32'(mem_we_o), 32'(we));
        chk("mem_addr", mem_addr_o, eadr);
        chk("mem_wstrb", 32'(mem_wstrb_o), estb);
        if (we) chk("mem_wdata", mem_wdata_o, ewd);
        chk("req_ready_in_req", 32'(req_ready_o), 32'd0);
        chk("no_wb_in_req", 32'(wb_valid_o), 32'd0);
        mem_req_ready_i = (i == mw);
        if (i == mw && same_rsp) begin
          mem_rsp_valid_i = 1'b1;
          mem_rdata_i = ~rdata;
        end
        tick();
      end
      mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
      for (int i = 0; i <= rw; i++) begin
        chk("memreq_dropped", 32'(mem_req_valid_o), 32'd0);
        chk("no_wb_in_wait", 32'(wb_valid_o), 32'd0);
        chk("req_ready_in_wait", 32'(req_ready_o), 32'd0);
        if (i == rw) begin
          mem_rsp_valid_i = 1'b1;
          mem_rdata_i = rdata;
        end
        tick();
      end
      mem_rsp_valid_i = 1'b0; mem_rdata_i = $urandom;
      if (we) begin
        chk("store_ready_back", 32'(req_ready_o), 32'd1);
        chk("store_no_wb", 32'(wb_valid_o), 32'd0);
      end else begin
        for (int i = 0; i <= ww; i++) begin
          chk("load_wb_valid", 32'(wb_valid_o), 32'd1);
          chk("load_no_misalign", 32'(wb_misalign_o), 32'd0);
          chk("load_wb_data", wb_data_o, eld);
          chk("load_wb_rd", 32'(wb_rd_o), 32'(rd));
          chk("load_ready_low", 32'(req_ready_o), 32'd0);
          wb_ready_i = (i == ww);
          tick();
        end
        wb_ready_i = 1'b0;
      end
    end
    if (!we || mis) begin
      chk("wb_released", 32'(wb_valid_o), 32'd0);
      chk("ready_after_wb", 32'(req_ready_o), 32'd1);
    end
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = '0;
    wb_ready_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;

    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_memreq", 32'(mem_req_valid_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_misalign", 32'(wb_misalign_o), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb_o), 32'd0);

    // Stray response while idle must change nothing.
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("idle_rsp_ignored_ready", 32'(req_ready_o), 32'd1);
    chk("idle_rsp_ignored_wb", 32'(wb_valid_o), 32'd0);

    // Signed byte load, zero-wait: wb_valid 3 cycles after accept.
    txn(1'b0, 0, 1'b0, 32'h8000_0003, 32'h0, 5'd7, 32'h80FF_1234, 0, 0, 0, 1'b0);
    // Unsigned half load.
    txn(1'b0, 1, 1'b1, 32'h8000_0002, 32'h0, 5'd9, 32'hBEEF_0000, 0, 0, 0, 1'b0);
    // Half store, zero-wait (3-cycle occupancy).
    txn(1'b1, 1, 1'b0, 32'h8000_0006, 32'h1234_ABCD, 5'd3, 32'h0, 0, 0, 0, 1'b0);
    // Misaligned word load.
    txn(1'b0, 2, 1'b0, 32'h8000_0001, 32'h0, 5'd12, 32'h0, 0, 0, 0, 1'b0);
    // Misaligned store, illegal size.
    txn(1'b1, 3, 1'b0, 32'h8000_0000, 32'h5555_AAAA, 5'd1, 32'h0, 0, 0, 1, 1'b0);
    // Backpressure: memory ready low 3 cycles, writeback ready low 2.
    txn(1'b0, 2, 1'b0, 32'h8000_0010, 32'h0, 5'd31, 32'hCAFE_F00D, 3, 0, 2, 1'b0);
    // Response in the handshake cycle must not count.
    txn(1'b0, 0, 1'b1, 32'h1000_0001, 32'h0, 5'd4, 32'h0000_9A00, 0, 1, 0, 1'b1);

    // Reset while waiting for a response, then a late response.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_unsigned_i = 1'b0;
    req_addr_i = 32'h8000_0020; req_rd_i = 5'd5;
    tick();
    req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    chk("pre_reset_in_wait", 32'(mem_req_valid_o), 32'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("abort_ready", 32'(req_ready_o), 32'd1);
    chk("abort_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("abort_memreq", 32'(mem_req_valid_o), 32'd0);
    tick();
    chk("abort_wb_valid_later", 32'(wb_valid_o), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      bit          we   = 1'($urandom);
      int          size = int'($urandom_range(0, 3));
      bit          uns  = 1'($urandom);
      logic [31:0] addr = $urandom;
      logic [31:0] wd   = $urandom;
      logic [4:0]  rd   = 5'($urandom);
      logic [31:0] rdv  = $urandom;
      txn(we, size, uns, addr, wd, rd, rdv,
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
          int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
